// File: rtl/udp_header_parser_pkg.sv
// Shared definitions for the UDP header parser: FSM encoding, header byte
// offsets and the fixed UDP header length.
package udp_header_parser_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR     = 3'd1;
  localparam state_t ST_PAYLOAD = 3'd2;
  localparam state_t ST_DONE    = 3'd3;
  localparam state_t ST_DROP    = 3'd4;

  localparam logic [2:0] SRC_HI  = 3'd0;
  localparam logic [2:0] SRC_LO  = 3'd1;
  localparam logic [2:0] DST_HI  = 3'd2;
  localparam logic [2:0] DST_LO  = 3'd3;
  localparam logic [2:0] LEN_HI  = 3'd4;
  localparam logic [2:0] LEN_LO  = 3'd5;
  localparam logic [2:0] CSUM_HI = 3'd6;
  localparam logic [2:0] CSUM_LO = 3'd7;

  localparam int UDP_HDR_LEN = 8;

endpackage

// File: rtl/udp_header_parser.sv
// UDP header parser: checks ports, extracts the length and forwards the
// payload as a registered stream with first/last markers and drop/trunc flags.
import udp_header_parser_pkg::*;

module udp_header_parser #(
  parameter int CHECK_SRC_PORT = 1,
  parameter int LEN_W          = 16
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             ipData,
  input  logic             ipInvalid,
  input  logic [7:0]       datain,
  input  logic [15:0]      PC_PORT,
  input  logic [15:0]      BOARD_PORT,
  output logic             payloadEn,
  output logic [7:0]       payloadData,
  output logic             payloadFirst,
  output logic             payloadLast,
  output logic [LEN_W-1:0] udpLen,
  output logic             isNotAValidPacket,
  output logic             truncErr
);

  state_t           r_state;
  logic [2:0]       r_hc;
  logic [LEN_W-1:0] r_rem;
  logic [7:0]       r_src_hi;
  logic [7:0]       r_dst_hi;
  logic [7:0]       r_len_hi;
  logic             r_first;

  logic [2:0]       w_idx;
  logic [15:0]      w_field;
  logic [LEN_W-1:0] w_len;
  logic             w_src_bad;
  logic             w_dst_bad;
  logic             w_len_bad;
  logic             w_hdr_bad;

  // The byte that moves IDLE into HDR is already header byte 0.
  assign w_idx     = (r_state == ST_IDLE) ? SRC_HI : r_hc;
  assign w_field   = (w_idx == SRC_LO) ? {r_src_hi, datain} :
                     (w_idx == DST_LO) ? {r_dst_hi, datain} :
                                         {r_len_hi, datain};
  assign w_len     = LEN_W'(w_field);
  assign w_src_bad = (CHECK_SRC_PORT != 0) && (w_idx == SRC_LO) && (w_field != PC_PORT);
  assign w_dst_bad = (w_idx == DST_LO) && (w_field != BOARD_PORT);
  assign w_len_bad = (w_idx == LEN_LO) && (w_field < 16'(UDP_HDR_LEN));
  assign w_hdr_bad = w_src_bad || w_dst_bad || w_len_bad;

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state           <= ST_IDLE;
      r_hc              <= '0;
      r_rem             <= '0;
      r_src_hi          <= '0;
      r_dst_hi          <= '0;
      r_len_hi          <= '0;
      r_first           <= 1'b0;
      payloadEn         <= 1'b0;
      payloadData       <= '0;
      payloadFirst      <= 1'b0;
      payloadLast       <= 1'b0;
      udpLen            <= '0;
      isNotAValidPacket <= 1'b0;
      truncErr          <= 1'b0;
    end else if (!ipData) begin
      // End of the packet window; report it if the packet ended early.
      truncErr          <= (r_state == ST_HDR) ||
                           ((r_state == ST_PAYLOAD) && (r_rem != '0));
      r_state           <= ST_IDLE;
      r_hc              <= '0;
      r_rem             <= '0;
      r_src_hi          <= '0;
      r_dst_hi          <= '0;
      r_len_hi          <= '0;
      r_first           <= 1'b0;
      payloadEn         <= 1'b0;
      payloadData       <= '0;
      payloadFirst      <= 1'b0;
      payloadLast       <= 1'b0;
      udpLen            <= '0;
      isNotAValidPacket <= 1'b0;
    end else begin
      payloadEn    <= 1'b0;
      payloadFirst <= 1'b0;
      payloadLast  <= 1'b0;
      truncErr     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HDR: begin
          case (w_idx)
            SRC_HI:  r_src_hi <= datain;
            DST_HI:  r_dst_hi <= datain;
            LEN_HI:  r_len_hi <= datain;
            LEN_LO: begin
              udpLen <= w_len;
              r_rem  <= w_len - LEN_W'(UDP_HDR_LEN);
            end
            default: ;
          endcase
          if (ipInvalid || w_hdr_bad) begin
            isNotAValidPacket <= 1'b1;
            r_state           <= ST_DROP;
          end else if (w_idx == CSUM_LO) begin
            // Checksum bytes are ignored; a zero checksum is legal.
            r_hc    <= '0;
            r_first <= 1'b1;
            r_state <= (r_rem == '0) ? ST_DONE : ST_PAYLOAD;
          end else begin
            r_hc    <= w_idx + 3'd1;
            r_state <= ST_HDR;
          end
        end
        ST_PAYLOAD: begin
          if (ipInvalid) begin
            isNotAValidPacket <= 1'b1;
            r_state           <= ST_DROP;
          end else begin
            payloadEn    <= 1'b1;
            payloadData  <= datain;
            payloadFirst <= r_first;
            payloadLast  <= (r_rem == LEN_W'(1));
            r_first      <= 1'b0;
            if (r_rem == LEN_W'(1)) begin
              r_state <= ST_DONE;
            end else begin
              r_rem <= r_rem - LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (ipInvalid) begin
            isNotAValidPacket <= 1'b1;
            r_state           <= ST_DROP;
          end
        end
        ST_DROP: begin
          isNotAValidPacket <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_header_parser.sv
// Scenario bench for udp_header_parser: expected payload beats are queued as
// bytes are driven and popped as the parser emits them.
module tb_udp_header_parser;

  logic        clock = 1'b0;
  logic        sclr = 1'b1;
  logic        ipData = 1'b0;
  logic        ipInvalid = 1'b0;
  logic [7:0]  datain = 8'h00;
  logic [15:0] PC_PORT = 16'h1F90;
  logic [15:0] BOARD_PORT = 16'h1F91;
  logic        payloadEn;
  logic [7:0]  payloadData;
  logic        payloadFirst;
  logic        payloadLast;
  logic [15:0] udpLen;
  logic        isNotAValidPacket;
  logic        truncErr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] pkt[$];
  logic [9:0] exp_q[$];

  udp_header_parser #(.CHECK_SRC_PORT(1), .LEN_W(16)) dut (
    .clock(clock), .sclr(sclr), .ipData(ipData), .ipInvalid(ipInvalid),
    .datain(datain), .PC_PORT(PC_PORT), .BOARD_PORT(BOARD_PORT),
    .payloadEn(payloadEn), .payloadData(payloadData),
    .payloadFirst(payloadFirst), .payloadLast(payloadLast), .udpLen(udpLen),
    .isNotAValidPacket(isNotAValidPacket), .truncErr(truncErr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  // Drive one byte and return just after the edge that registers it.
  task automatic step(input logic en, input logic inv, input logic [7:0] d);
    @(negedge clock);
    ipData = en; ipInvalid = inv; datain = d;
    @(posedge clock);
    #1;
  endtask

  task automatic build_hdr(input logic [15:0] s, input logic [15:0] dp, input logic [15:0] l);
    pkt.delete();
    pkt.push_back(s[15:8]);  pkt.push_back(s[7:0]);
    pkt.push_back(dp[15:8]); pkt.push_back(dp[7:0]);
    pkt.push_back(l[15:8]);  pkt.push_back(l[7:0]);
    pkt.push_back(8'h00);    pkt.push_back(8'h00);
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    step(1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 8'hFF);
    n_cmp++;
    if ({payloadEn, payloadFirst, payloadLast, isNotAValidPacket, truncErr, payloadData, udpLen} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b f=%b l=%b inv=%b tr=%b d=%h len=%h, want all 0",
               payloadEn, payloadFirst, payloadLast, isNotAValidPacket, truncErr, payloadData, udpLen);
    end
    sclr = 1'b0;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_valid();
    logic [9:0] e;
    build_hdr(16'h1F90, 16'h1F91, 16'h000C);
    pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC); pkt.push_back(8'hDD);
    for (int k = 0; k < 6; k++) pkt.push_back(8'h00);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i >= 8 && i < 12) exp_q.push_back({pkt[i], 1'(i == 8), 1'(i == 11)});
      step(1'b1, 1'b0, pkt[i]);
      n_cmp++;
      if (payloadEn !== (exp_q.size() != 0)) begin
        n_bad++;
        $display("FAIL valid_en byte %0d: got %b want %b", i, payloadEn, exp_q.size() != 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (payloadEn) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({payloadData, payloadFirst, payloadLast} !== e) begin
          n_bad++;
          $display("FAIL valid_beat byte %0d: got d=%h f=%b l=%b want d=%h f=%b l=%b",
                   i, payloadData, payloadFirst, payloadLast, e[9:2], e[1], e[0]);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (udpLen !== 16'd12) begin
          n_bad++; $display("FAIL valid_udplen: got %0d want 12", udpLen);
        end
      end
    end
    n_cmp++;
    if (isNotAValidPacket !== 1'b0 || udpLen !== 16'd12) begin
      n_bad++;
      $display("FAIL valid_end: got inv=%b len=%0d want inv=0 len=12", isNotAValidPacket, udpLen);
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({truncErr, isNotAValidPacket, payloadEn, udpLen} !== 19'd0) begin
      n_bad++;
      $display("FAIL valid_close: got tr=%b inv=%b en=%b len=%h want all 0", truncErr, isNotAValidPacket, payloadEn, udpLen);
    end
  endtask

  task automatic test_dst_mismatch();
    build_hdr(16'h1F90, 16'h1F92, 16'h000C);
    pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03); pkt.push_back(8'h04);
    for (int i = 0; i < pkt.size(); i++) begin
      step(1'b1, 1'b0, pkt[i]);
      n_cmp++;
      if (payloadEn !== 1'b0 || isNotAValidPacket !== (i >= 3)) begin
        n_bad++;
        $display("FAIL dst_byte %0d: got en=%b inv=%b want en=0 inv=%b", i, payloadEn, isNotAValidPacket, i >= 3);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (isNotAValidPacket !== 1'b0 || truncErr !== 1'b0) begin
      n_bad++;
      $display("FAIL dst_clear: got inv=%b tr=%b want 0 0", isNotAValidPacket, truncErr);
    end
  endtask

  task automatic test_len8();
    build_hdr(16'h1F90, 16'h1F91, 16'h0008);
    pkt.push_back(8'h55); pkt.push_back(8'h66);
    for (int i = 0; i < pkt.size(); i++) begin
      step(1'b1, 1'b0, pkt[i]);
      n_cmp++;
      if (payloadEn !== 1'b0 || truncErr !== 1'b0 || isNotAValidPacket !== 1'b0) begin
        n_bad++;
        $display("FAIL len8_byte %0d: got en=%b tr=%b inv=%b want 0 0 0", i, payloadEn, truncErr, isNotAValidPacket);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (truncErr !== 1'b0) begin
      n_bad++; $display("FAIL len8_trunc: got %b want 0", truncErr);
    end
  endtask

  task automatic test_len5();
    build_hdr(16'h1F90, 16'h1F91, 16'h0005);
    for (int i = 0; i < pkt.size(); i++) begin
      step(1'b1, 1'b0, pkt[i]);
      n_cmp++;
      if (payloadEn !== 1'b0 || isNotAValidPacket !== (i >= 5)) begin
        n_bad++;
        $display("FAIL len5_byte %0d: got en=%b inv=%b want en=0 inv=%b", i, payloadEn, isNotAValidPacket, i >= 5);
      end
    end
    step(1'b1, 1'b0, 8'h77);
    n_cmp++;
    if (isNotAValidPacket !== 1'b1 || udpLen !== 16'd5) begin
      n_bad++; $display("FAIL len5_hold: got inv=%b len=%0d want 1 5", isNotAValidPacket, udpLen);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_ip_invalid();
    build_hdr(16'h1F90, 16'h1F91, 16'h000A);
    pkt.push_back(8'h10); pkt.push_back(8'h20);
    for (int i = 0; i < pkt.size(); i++) begin
      step(1'b1, 1'(i == 1), pkt[i]);
      n_cmp++;
      if (payloadEn !== 1'b0 || isNotAValidPacket !== (i >= 1)) begin
        n_bad++;
        $display("FAIL ipinv_byte %0d: got en=%b inv=%b want en=0 inv=%b", i, payloadEn, isNotAValidPacket, i >= 1);
      end
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_truncation();
    logic [9:0] e;
    build_hdr(16'h1F90, 16'h1F91, 16'h0010);
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i >= 8) exp_q.push_back({pkt[i], 1'(i == 8), 1'b0});
      step(1'b1, 1'b0, pkt[i]);
      n_cmp++;
      if (payloadEn !== (exp_q.size() != 0)) begin
        n_bad++;
        $display("FAIL trunc_en byte %0d: got %b want %b", i, payloadEn, exp_q.size() != 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (payloadEn) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({payloadData, payloadFirst, payloadLast} !== e) begin
          n_bad++;
          $display("FAIL trunc_beat byte %0d: got d=%h f=%b l=%b want d=%h f=%b l=%b",
                   i, payloadData, payloadFirst, payloadLast, e[9:2], e[1], e[0]);
        end
      end
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (truncErr !== 1'b1 || payloadEn !== 1'b0 || isNotAValidPacket !== 1'b0 || udpLen !== 16'd0) begin
      n_bad++;
      $display("FAIL trunc_pulse: got tr=%b en=%b inv=%b len=%h want 1 0 0 0", truncErr, payloadEn, isNotAValidPacket, udpLen);
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (truncErr !== 1'b0) begin
      n_bad++; $display("FAIL trunc_width: got tr=%b want 0 on second cycle", truncErr);
    end
  endtask

  task automatic test_sclr_and_restart();
    logic [9:0] e;
    build_hdr(16'h1F90, 16'h1F91, 16'h000C);
    pkt.push_back(8'hAA); pkt.push_back(8'hBB);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i >= 8) exp_q.push_back({pkt[i], 1'(i == 8), 1'b0});
      step(1'b1, 1'b0, pkt[i]);
      if (payloadEn) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({payloadData, payloadFirst, payloadLast} !== e) begin
          n_bad++;
          $display("FAIL sclr_pre_beat byte %0d: got d=%h f=%b l=%b want d=%h f=%b l=%b",
                   i, payloadData, payloadFirst, payloadLast, e[9:2], e[1], e[0]);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL sclr_pre_count: got %0d beats pending want 0", exp_q.size());
      exp_q.delete();
    end
    sclr = 1'b1;
    step(1'b1, 1'b0, 8'hCC);
    sclr = 1'b0;
    n_cmp++;
    if ({payloadEn, payloadFirst, payloadLast, isNotAValidPacket, truncErr, payloadData, udpLen} !== 29'd0) begin
      n_bad++;
      $display("FAIL sclr_outputs: got en=%b f=%b l=%b inv=%b tr=%b d=%h len=%h want all 0",
               payloadEn, payloadFirst, payloadLast, isNotAValidPacket, truncErr, payloadData, udpLen);
    end
    step(1'b0, 1'b0, 8'h00);
    // Fresh packet with a single payload byte: first and last together.
    build_hdr(16'h1F90, 16'h1F91, 16'h0009);
    pkt.push_back(8'h5A); pkt.push_back(8'hEE);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == 8) exp_q.push_back({pkt[i], 1'b1, 1'b1});
      step(1'b1, 1'b0, pkt[i]);
      n_cmp++;
      if (payloadEn !== (exp_q.size() != 0)) begin
        n_bad++;
        $display("FAIL restart_en byte %0d: got %b want %b", i, payloadEn, exp_q.size() != 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (payloadEn) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({payloadData, payloadFirst, payloadLast} !== e) begin
          n_bad++;
          $display("FAIL restart_beat byte %0d: got d=%h f=%b l=%b want d=%h f=%b l=%b",
                   i, payloadData, payloadFirst, payloadLast, e[9:2], e[1], e[0]);
        end
      end
    end
    n_cmp++;
    if (udpLen !== 16'd9 || isNotAValidPacket !== 1'b0) begin
      n_bad++; $display("FAIL restart_len: got len=%0d inv=%b want 9 0", udpLen, isNotAValidPacket);
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_valid();
    test_dst_mismatch();
    test_len8();
    test_len5();
    test_ip_invalid();
    test_truncation();
    test_sclr_and_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
